ram_port_arbiter: RTL and testbench



---
 rtl/ram_port_arbiter.sv | 128 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Purpose: round-robin arbiter/sequencer sharing one single-port synchronous RAM between two requesters.
// Latency: write grant 1 cycle after capture; read data/rvalid 3 cycles after capture (one read per 3 cycles).
// Backpressure: requesters hold req (stable addr/data) until their gnt pulse; requests seen while busy wait for IDLE.
//
// Ports:
//   clock, reset               rising-edge clock, synchronous active-high reset
//   reqN/wrN/addrN/wdataN      requester N access request (N = 0 CPU path, 1 I/O-DMA path)
//   gntN                       one-cycle pulse: requester N's access is on the RAM port this cycle
//   rvalidN/rdataN             one-cycle pulse / held read-data register for requester N
//   mem_addr/mem_din/mem_write RAM command, valid for exactly one cycle per access
//   mem_dout                   RAM read data, one cycle after the address
//   busy                       high whenever the sequencer is not idle
module ram_port_arbiter #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_write,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, READ_WAIT} state_t;

  state_t state;
  logic   last;    // index of the requester that won the previous capture
  logic   win;     // index of the requester currently being served
  logic   cap_wr;  // captured access direction of the current winner
  logic   pick;    // arbitration result for this cycle

  // A contested round goes to whoever did not win last time; an
  // uncontested one simply goes to the lone requester.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = ~last;
    end else if (req1) begin
      pick = 1'b1;
    end
  end

  // All outputs are registered: the command is loaded at the capture edge
  // so it appears on the RAM port during the ISSUE cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      win       <= 1'b0;
      cap_wr    <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (req0 || req1) begin
            win       <= pick;
            last      <= pick;
            cap_wr    <= pick ? wr1 : wr0;
            mem_addr  <= pick ? addr1 : addr0;
            mem_din   <= pick ? wdata1 : wdata0;
            mem_write <= pick ? wr1 : wr0;
            gnt0      <= ~pick;
            gnt1      <= pick;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // mem_addr stays put so the RAM output still belongs to this read.
          if (cap_wr) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            busy  <= 1'b1;
            state <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (win) begin
            rdata1  <= mem_dout;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= mem_dout;
            rvalid0 <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Purpose: directed self-checking bench for ram_port_arbiter with a behavioural single-port RAM.
// Latency: expected grant/rvalid cycles are hand-derived relative to the first request negedge.
// Backpressure: bench requesters hold req until gnt, then present their next queued op or drop req.
module tb_ram_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, wr0, req1, wr1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din;
  logic        mem_write;
  logic [15:0] mem_dout;
  logic        busy;

  always #5 clock = ~clock;

  ram_port_arbiter #(.DW(16), .AW(8)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_write(mem_write),
    .mem_dout(mem_dout), .busy(busy)
  );

  // Behavioural synchronous single-port RAM; ram_clr zeroes it once at start.
  logic        ram_clr;
  logic [15:0] ram [256];
  always @(posedge clock) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (mem_write) begin
      ram[mem_addr] <= mem_din;
    end
    mem_dout <= ram[mem_addr];
  end

  typedef struct {
    logic        wr;
    logic [7:0]  a;
    logic [15:0] d;
  } op_t;

  op_t         q0[$], q1[$];
  int          g_port[$], g_cyc[$];
  logic        g_mw[$];
  logic [7:0]  g_ma[$];
  logic [15:0] g_md[$];
  logic [15:0] rv0_d[$], rv1_d[$];
  int          rv0_c[$], rv1_c[$];
  int          viol;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic op_t mk(input logic wr, input logic [7:0] a, input logic [15:0] d);
    op_t o;
    o.wr = wr;
    o.a  = a;
    o.d  = d;
    return o;
  endfunction

  // Drives both requesters from their op queues, one step per negedge.
  // Cycle c = 0 is the negedge where requests are first presented.
  task automatic run(input int st0, input int st1);
    bit done;
    done = 1'b0;
    g_port.delete(); g_cyc.delete(); g_mw.delete(); g_ma.delete(); g_md.delete();
    rv0_d.delete(); rv1_d.delete(); rv0_c.delete(); rv1_c.delete();
    viol = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      if (c > 0) begin
        if (gnt0 && gnt1) viol++;
        if (mem_write && !(gnt0 || gnt1)) viol++;
        if ((rvalid0 && gnt0) || (rvalid1 && gnt1)) viol++;
        if (gnt0 || gnt1) begin
          g_port.push_back(gnt1 ? 1 : 0);
          g_cyc.push_back(c);
          g_mw.push_back(mem_write);
          g_ma.push_back(mem_addr);
          g_md.push_back(mem_din);
        end
        if (gnt0 && q0.size() > 0) q0.delete(0);
        if (gnt1 && q1.size() > 0) q1.delete(0);
        if (rvalid0) begin rv0_d.push_back(rdata0); rv0_c.push_back(c); end
        if (rvalid1) begin rv1_d.push_back(rdata1); rv1_c.push_back(c); end
      end
      req0 = (q0.size() > 0) && (c >= st0);
      if (q0.size() > 0) begin wr0 = q0[0].wr; addr0 = q0[0].a; wdata0 = q0[0].d; end
      req1 = (q1.size() > 0) && (c >= st1);
      if (q1.size() > 0) begin wr1 = q1[0].wr; addr1 = q1[0].a; wdata1 = q1[0].d; end
      if (c > 0 && q0.size() == 0 && q1.size() == 0 && !busy) done = 1'b1;
    end
    check("run_complete", {31'b0, done}, 32'd1);
    check("run_protocol_rules", viol, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ram_clr = 1'b1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h00; wdata0 = 16'h0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = 8'h00; wdata1 = 16'h0;

    // Reset held two cycles with req0 high: nothing may be granted.
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("reset_gnt0", gnt0, 0);
      check("reset_busy", busy, 0);
      check("reset_mem_write", mem_write, 0);
      check("reset_mem_addr", mem_addr, 0);
      check("reset_rdata0", rdata0, 0);
    end
    reset = 1'b0; ram_clr = 1'b0;
    @(negedge clock);
    check("post_reset_gnt0_cycle1", gnt0, 1);
    check("post_reset_gnt1", gnt1, 0);
    req0 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("post_reset_rvalid0", rvalid0, 1);
    check("post_reset_rdata0", rdata0, 16'h0000);

    // Single write then read from requester 0.
    q0.push_back(mk(1'b1, 8'h05, 16'hBEEF));
    q0.push_back(mk(1'b0, 8'h05, 16'h0000));
    run(0, 0);
    check("wr_grant_count", g_port.size(), 2);
    check("wr_gnt_cycle", g_cyc[0], 1);
    check("wr_mem_write", g_mw[0], 1);
    check("wr_mem_addr", g_ma[0], 8'h05);
    check("wr_mem_din", g_md[0], 16'hBEEF);
    check("rd_gnt_cycle", g_cyc[1], 3);
    check("rd_mem_write", g_mw[1], 0);
    check("rd_rvalid_cycle", rv0_c[0], 5);
    check("rd_rdata0", rv0_d[0], 16'hBEEF);
    check("rd_rdata1_untouched", rdata1, 16'h0000);

    // rdata1 must hold across four requester-0 accesses.
    q1.push_back(mk(1'b1, 8'h20, 16'h1234));
    q1.push_back(mk(1'b0, 8'h20, 16'h0000));
    run(0, 0);
    check("hold_rdata1_loaded", rdata1, 16'h1234);
    q0.push_back(mk(1'b1, 8'h30, 16'hAAAA));
    q0.push_back(mk(1'b0, 8'h30, 16'h0000));
    q0.push_back(mk(1'b1, 8'h31, 16'h5555));
    q0.push_back(mk(1'b0, 8'h31, 16'h0000));
    run(0, 0);
    check("hold_rdata1_kept", rdata1, 16'h1234);
    check("hold_rvalid1_count", rv1_d.size(), 0);
    check("hold_rv0_first", rv0_d[0], 16'hAAAA);
    check("hold_rdata0_final", rdata0, 16'h5555);

    // Preload; the second write comes from requester 1 so it won last.
    q0.push_back(mk(1'b1, 8'h40, 16'h1111));
    run(0, 0);
    q1.push_back(mk(1'b1, 8'h41, 16'h2222));
    run(0, 0);

    // Contention: both hold read requests; grants alternate 0,1,0,1.
    q0.push_back(mk(1'b0, 8'h40, 16'h0));
    q0.push_back(mk(1'b0, 8'h40, 16'h0));
    q1.push_back(mk(1'b0, 8'h41, 16'h0));
    q1.push_back(mk(1'b0, 8'h41, 16'h0));
    run(0, 0);
    check("cont_grant_count", g_port.size(), 4);
    check("cont_order0", g_port[0], 0);
    check("cont_order1", g_port[1], 1);
    check("cont_order2", g_port[2], 0);
    check("cont_order3", g_port[3], 1);
    check("cont_gnt1_cycle", g_cyc[1], 4);
    check("cont_rv0_a", rv0_d[0], 16'h1111);
    check("cont_rv0_b", rv0_d[1], 16'h1111);
    check("cont_rv1_a", rv1_d[0], 16'h2222);
    check("cont_rv1_b", rv1_d[1], 16'h2222);

    // Back-to-back: req1 stays high across gnt1 with a new address while req0 waits.
    q1.push_back(mk(1'b1, 8'h50, 16'h0A0A));
    q1.push_back(mk(1'b1, 8'h51, 16'h0B0B));
    q0.push_back(mk(1'b0, 8'h50, 16'h0));
    run(1, 0);
    check("b2b_grant_count", g_port.size(), 3);
    check("b2b_order0", g_port[0], 1);
    check("b2b_order1", g_port[1], 0);
    check("b2b_order2", g_port[2], 1);
    check("b2b_gnt0_cycle", g_cyc[1], 3);
    check("b2b_second_addr", g_ma[2], 8'h51);
    check("b2b_rv0", rv0_d[0], 16'h0A0A);
    q0.push_back(mk(1'b0, 8'h51, 16'h0));
    run(0, 0);
    check("b2b_second_write", rv0_d[0], 16'h0B0B);

    // Reset during READ_WAIT of a requester-0 read (requester 0 won last).
    @(negedge clock);
    req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h40;
    @(negedge clock);
    check("midrst_gnt0", gnt0, 1);
    req0 = 1'b0;
    @(negedge clock);
    check("midrst_busy_in_wait", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_rvalid0", rvalid0, 0);
    check("midrst_rdata0", rdata0, 16'h0000);
    check("midrst_rdata1", rdata1, 16'h0000);
    check("midrst_busy", busy, 0);
    check("midrst_mem_addr", mem_addr, 8'h00);
    @(negedge clock);
    check("midrst_no_late_rvalid0", rvalid0, 0);

    q0.push_back(mk(1'b0, 8'h40, 16'h0));
    q1.push_back(mk(1'b0, 8'h41, 16'h0));
    run(0, 0);
    check("midrst_first_winner", g_port[0], 0);
    check("midrst_second_winner", g_port[1], 1);
    check("midrst_rv0", rv0_d[0], 16'h1111);
    check("midrst_rv1", rv1_d[0], 16'h2222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
